mini_ctrl_sequencer: RTL and testbench



---
 rtl/mini_ctrl_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_mini_ctrl_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mini_ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute control sequencer for the 32-bit CPU datapath.
// Optional illegal-opcode trap: define ILLEGAL_OP_TRAP_EN.
module mini_ctrl_sequencer #(
    parameter int                  OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0] ADD_OP   = 5'b00011
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                con_ff,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Yin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                CONin,
    output logic                Cout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                Read,
    output logic                Write,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                run,
    output logic                illegal
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_RALU, C_IALU, C_BR, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t              r_state;
    state_t              w_next;
    cls_t                r_cls;
    cls_t                w_cls;
    logic [OPCODE_W-1:0] r_alu;
    logic [OPCODE_W-1:0] w_alu;

    // Opcode is only valid from T3 on, so T3 decodes it live and later states use the latched class.
    always_comb begin
        w_alu = ADD_OP;
        case (opcode) inside
            5'b00000:                   w_cls = C_LD;
            5'b00001:                   w_cls = C_LDI;
            5'b00010:                   w_cls = C_ST;
            [5'b00011:5'b01100]: begin  w_cls = C_RALU; w_alu = opcode; end
            5'b01101: begin             w_cls = C_IALU; w_alu = 5'b00011; end
            5'b01110: begin             w_cls = C_IALU; w_alu = 5'b00101; end
            5'b01111: begin             w_cls = C_IALU; w_alu = 5'b00110; end
            5'b10010:                   w_cls = C_BR;
            5'b11010:                   w_cls = C_NOP;
            5'b11011:                   w_cls = C_HALT;
            default:                    w_cls = C_ILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
            r_cls   <= C_NOP;
            r_alu   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T3) begin
                r_cls <= w_cls;
                r_alu <= w_alu;
            end
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_T3 && w_cls == C_ILL) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // NOTE: every output and the next state get a default first, so no path through the case infers a latch.
    always_comb begin
        w_next  = r_state;
        PCout   = 1'b0; MARin  = 1'b0; IncPC  = 1'b0; PCin  = 1'b0;
        Zin     = 1'b0; Zlowout = 1'b0; Yin   = 1'b0; MDRin = 1'b0;
        MDRout  = 1'b0; IRin   = 1'b0; CONin  = 1'b0; Cout  = 1'b0;
        Gra     = 1'b0; Grb    = 1'b0; Grc    = 1'b0; Rin   = 1'b0;
        Rout    = 1'b0; BAout  = 1'b0; Read   = 1'b0; Write = 1'b0;
        alu_op  = '0;
        run     = 1'b1;

        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_ready) w_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                w_next = S_T4;
                case (w_cls)
                    C_RALU, C_IALU: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_HALT: w_next = S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
                    C_ILL:  w_next = S_HALT;
`endif
                    default: w_next = S_T0;
                endcase
            end
            S_T4: begin
                w_next = S_T5;
                if (r_cls == C_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    Zin = 1'b1; alu_op = r_alu;
                    if (r_cls == C_RALU) begin
                        Grc = 1'b1; Rout = 1'b1;
                    end else begin
                        Cout = 1'b1;
                    end
                end
            end
            S_T5: begin
                case (r_cls)
                    C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; w_next = S_T6; end
                    C_BR: begin Cout = 1'b1; alu_op = r_alu; Zin = 1'b1; w_next = S_T6; end
                    default: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_next = S_T0; end
                endcase
            end
            S_T6: begin
                case (r_cls)
                    C_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                        if (mem_ready) w_next = S_T7;
                    end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; w_next = S_T7; end
                    default: begin
                        Zlowout = con_ff; PCin = con_ff;
                        w_next = S_T0;
                    end
                endcase
            end
            S_T7: begin
                if (r_cls == C_ST) begin
                    Write = 1'b1;
                    if (mem_ready) w_next = S_T0;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    w_next = S_T0;
                end
            end
            S_HALT: run = 1'b0;
            default: w_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mini_ctrl_sequencer.sv
// Directed self-checking bench for mini_ctrl_sequencer: fetch, each opcode class, memory waits, reset, halt.
module tb_mini_ctrl_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] opcode;
    logic       con_ff;
    logic       mem_ready;
    logic PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout, IRin, CONin, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write;
    logic [4:0] alu_op;
    logic       run;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [19:0] S_PCOUT = 20'h80000, S_MARIN = 20'h40000, S_INCPC = 20'h20000,
                            S_PCIN  = 20'h10000, S_ZIN   = 20'h08000, S_ZLOW  = 20'h04000,
                            S_YIN   = 20'h02000, S_MDRIN = 20'h01000, S_MDROUT = 20'h00800,
                            S_IRIN  = 20'h00400, S_CONIN = 20'h00200, S_COUT  = 20'h00100,
                            S_GRA   = 20'h00080, S_GRB   = 20'h00040, S_GRC   = 20'h00020,
                            S_RIN   = 20'h00010, S_ROUT  = 20'h00008, S_BAOUT = 20'h00004,
                            S_READ  = 20'h00002, S_WRITE = 20'h00001, S_NONE  = 20'h00000;
    localparam logic [19:0] E_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [19:0] E_T1 = S_ZLOW | S_PCIN | S_READ | S_MDRIN;
    localparam logic [19:0] E_T2 = S_MDROUT | S_IRIN;
    localparam logic [4:0]  ADD  = 5'b00011;

    mini_ctrl_sequencer dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .con_ff(con_ff), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Zin(Zin), .Zlowout(Zlowout),
        .Yin(Yin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .CONin(CONin), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [26:0] observed, input logic [26:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: got run/ill/alu/strb=%h want %h", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input string tag, input logic [19:0] strb, input logic [4:0] alu,
                              input logic run_e, input logic ill_e);
        check(tag,
              {run, illegal, alu_op,
               PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout, IRin, CONin, Cout,
               Gra, Grb, Grc, Rin, Rout, BAout, Read, Write},
              {run_e, ill_e, alu, strb});
    endtask

    // Starts sampled in T0 and returns sampled in T3, with mem_ready high through T1.
    task automatic fetch(input string tag);
        expect_out({tag, "_t0"}, E_T0, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out({tag, "_t1"}, E_T1, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out({tag, "_t2"}, E_T2, 5'd0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 5'b00011;
        con_ff    = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        expect_out("rst", S_NONE, 5'd0, 1'b1, 1'b0);
        reset_n = 1'b1;
        tick();

        // add: T0 on cycle 1, T5 on cycle 6, T0 again on cycle 7
        fetch("add");
        expect_out("add_t3", S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("add_t4", S_GRC | S_ROUT | S_ZIN, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_out("add_t5", S_ZLOW | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0);
        tick();

        // ori uses alu_op 00110
        opcode = 5'b01111;
        fetch("ori");
        expect_out("ori_t3", S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("ori_t4", S_COUT | S_ZIN, 5'b00110, 1'b1, 1'b0);
        tick();
        expect_out("ori_t5", S_ZLOW | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0);
        tick();

        // ld with three wait cycles in T6
        opcode = 5'b00000;
        fetch("ld");
        expect_out("ld_t3", S_GRB | S_BAOUT | S_YIN, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("ld_t4", S_COUT | S_ZIN, ADD, 1'b1, 1'b0);
        tick();
        expect_out("ld_t5", S_ZLOW | S_MARIN, 5'd0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out($sformatf("ld_t6_%0d", i), S_READ | S_MDRIN, 5'd0, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        tick();
        expect_out("ld_t7", S_MDROUT | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0);
        tick();

        // st with Write held over two cycles
        opcode = 5'b00010;
        fetch("st");
        expect_out("st_t3", S_GRB | S_BAOUT | S_YIN, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("st_t4", S_COUT | S_ZIN, ADD, 1'b1, 1'b0);
        tick();
        expect_out("st_t5", S_ZLOW | S_MARIN, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("st_t6", S_GRA | S_ROUT | S_MDRIN, 5'd0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        tick();
        expect_out("st_t7a", S_WRITE, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("st_t7b", S_WRITE, 5'd0, 1'b1, 1'b0);
        mem_ready = 1'b1;
        tick();

        // branch taken, then not taken
        opcode = 5'b10010;
        for (int t = 1; t >= 0; t--) begin
            con_ff = t[0];
            fetch($sformatf("br%0d", t));
            expect_out("br_t3", S_GRA | S_ROUT | S_CONIN, 5'd0, 1'b1, 1'b0);
            tick();
            expect_out("br_t4", S_PCOUT | S_YIN, 5'd0, 1'b1, 1'b0);
            tick();
            expect_out("br_t5", S_COUT | S_ZIN, ADD, 1'b1, 1'b0);
            tick();
            expect_out($sformatf("br%0d_t6", t), (t == 1) ? (S_ZLOW | S_PCIN) : S_NONE,
                       5'd0, 1'b1, 1'b0);
            tick();
        end

        // nop
        opcode = 5'b11010;
        fetch("nop");
        expect_out("nop_t3", S_NONE, 5'd0, 1'b1, 1'b0);
        tick();

        // illegal opcode
        opcode = 5'b10111;
        fetch("ill");
        expect_out("ill_t3", S_NONE, 5'd0, 1'b1, 1'b0);
        tick();
`ifdef ILLEGAL_OP_TRAP_EN
        expect_out("ill_halt0", S_NONE, 5'd0, 1'b0, 1'b1);
        tick();
        expect_out("ill_halt1", S_NONE, 5'd0, 1'b0, 1'b1);
`else
        expect_out("ill_as_nop", E_T0, 5'd0, 1'b1, 1'b0);
`endif
        reset_n = 1'b0;
        #1;
        expect_out("rst2", S_NONE, 5'd0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b1;
        tick();

        // reset asserted in the middle of a T1 memory wait
        expect_out("rw_t0", E_T0, 5'd0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        tick();
        tick();
        expect_out("rw_t1_wait", E_T1, 5'd0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("rw_async", S_NONE, 5'd0, 1'b1, 1'b0);
        #2;
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        tick();

        // halt holds run low until reset
        opcode = 5'b11011;
        fetch("halt");
        expect_out("halt_t3", S_NONE, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out($sformatf("halt_%0d", i), S_NONE, 5'd0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
